// File: rtl/cpu_pkg.sv
// cpu_pkg: shared instruction-type codes, FSM state and register-file constants
package cpu_pkg;
    localparam int NUM_REGS = 32;
    typedef enum logic [3:0] {
        INST_INVALID = 4'd0,
        INST_R       = 4'd1,
        INST_I       = 4'd2,
        INST_I_MEM   = 4'd3,
        INST_S       = 4'd4,
        INST_B       = 4'd5,
        INST_U       = 4'd6,
        INST_J       = 4'd7,
        INST_R4      = 4'd8
    } inst_type_t;
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } sb_state_t;
endpackage

// File: rtl/reg_use_decode.sv
// reg_use_decode: maps an instruction type to its register usage and immediate flag
module reg_use_decode
    import cpu_pkg::*;
(
    input  logic [3:0] dec_type,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       uses_rs3,
    output logic       writes_rd,
    output logic       is_immediate
);
    // unknown codes fall out of every set and behave like INVALID
    always_comb begin
        uses_rs1     = dec_type inside {INST_R, INST_S, INST_B, INST_I, INST_I_MEM, INST_R4};
        uses_rs2     = dec_type inside {INST_R, INST_S, INST_B, INST_R4};
        uses_rs3     = dec_type == INST_R4;
        writes_rd    = dec_type inside {INST_R, INST_I, INST_I_MEM, INST_U, INST_J, INST_R4};
        is_immediate = dec_type inside {INST_I, INST_I_MEM, INST_S, INST_B, INST_U, INST_J};
    end
endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: tracks in-flight register writes, stalls decode on hazards, drains on flush
module issue_scoreboard
    import cpu_pkg::*;
#(
    parameter int WORD_SIZE       = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                dec_valid,
    output logic                dec_ready,
    input  logic [3:0]          dec_type,
    input  logic [4:0]          dec_rs1,
    input  logic [4:0]          dec_rs2,
    input  logic [4:0]          dec_rs3,
    input  logic [4:0]          dec_rd,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    input  logic                flush,
    output logic                issue_valid,
    output logic                issue_is_write,
    output logic                issue_is_immediate,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [3:0]          outstanding,
    output logic [15:0]         stall_cycles
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15 || WORD_SIZE < 1) begin : g_bad_param
        $error("issue_scoreboard: MAX_OUTSTANDING must be 1..15 and WORD_SIZE positive");
    end

    sb_state_t           state;
    logic                uses_rs1, uses_rs2, uses_rs3, writes_rd, is_immediate;
    logic [NUM_REGS-1:0] wb_hot, set_hot, eff_busy;
    logic                wb_hit, rd_tracked, hazard, accept;
    logic [3:0]          cnt_next;

    reg_use_decode u_dec (
        .dec_type    (dec_type),
        .uses_rs1    (uses_rs1),
        .uses_rs2    (uses_rs2),
        .uses_rs3    (uses_rs3),
        .writes_rd   (writes_rd),
        .is_immediate(is_immediate)
    );

    // hazard detection sees this cycle's writeback as already released
    always_comb begin
        wb_hot     = wb_valid ? NUM_REGS'(1) << wb_rd : '0;
        eff_busy   = busy_mask & ~wb_hot;
        wb_hit     = wb_valid & busy_mask[wb_rd];
        rd_tracked = writes_rd & (dec_rd != '0);
        hazard     = (uses_rs1 & eff_busy[dec_rs1]) | (uses_rs2 & eff_busy[dec_rs2])
                   | (uses_rs3 & eff_busy[dec_rs3]) | (rd_tracked & eff_busy[dec_rd])
                   | (rd_tracked & (outstanding == MAX_CNT) & ~wb_hit);
        dec_ready  = (state == ST_RUN) & ~hazard & ~flush;
        accept     = dec_valid & dec_ready;
        stall      = dec_valid & ~dec_ready;
        set_hot    = (accept & rd_tracked) ? NUM_REGS'(1) << dec_rd : '0;
        cnt_next   = outstanding + 4'(accept & rd_tracked) - 4'(wb_hit);
    end

    // run/drain sequencing and registered issue controls for execute
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_RUN;
            issue_valid        <= 1'b0;
            issue_is_write     <= 1'b0;
            issue_is_immediate <= 1'b0;
        end else begin
            state              <= (state == ST_RUN) ? (flush ? ST_DRAIN : ST_RUN)
                                                    : ((cnt_next == '0) ? ST_RUN : ST_DRAIN);
            issue_valid        <= accept & (dec_type != INST_INVALID);
            issue_is_write     <= accept & writes_rd;
            issue_is_immediate <= accept & is_immediate;
        end
    end

    // busy bits, outstanding count and saturating stall counter; a same-cycle set beats the clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_mask    <= '0;
            outstanding  <= '0;
            stall_cycles <= '0;
        end else begin
            busy_mask    <= eff_busy | set_hot;
            outstanding  <= cnt_next;
            stall_cycles <= stall_cycles + 16'(stall && stall_cycles != 16'hFFFF);
        end
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed plus random stimulus against a queue-based reference model
module tb_issue_scoreboard;
    import cpu_pkg::*;
    localparam int MAXO = 4;

    logic        clock = 1'b0, reset_n = 1'b0;
    logic        dec_valid = 1'b0, wb_valid = 1'b0, flush = 1'b0;
    logic [3:0]  dec_type = '0;
    logic [4:0]  dec_rs1 = '0, dec_rs2 = '0, dec_rs3 = '0, dec_rd = '0, wb_rd = '0;
    logic        dec_ready, issue_valid, issue_is_write, issue_is_immediate, stall;
    logic [31:0] busy_mask;
    logic [3:0]  outstanding;
    logic [15:0] stall_cycles;

    issue_scoreboard #(.WORD_SIZE(32), .MAX_OUTSTANDING(MAXO)) dut (
        .clock(clock), .reset_n(reset_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_type(dec_type), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3),
        .dec_rd(dec_rd), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .issue_valid(issue_valid), .issue_is_write(issue_is_write),
        .issue_is_immediate(issue_is_immediate), .stall(stall), .busy_mask(busy_mask),
        .outstanding(outstanding), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    typedef struct {bit w; bit i;} exp_t;
    exp_t q[$];
    bit   mb[32];
    int   mcnt, mstall, n_chk, n_fail;
    bit   mdrain;

    function automatic bit m_src(int t, int k);
        if (k == 1) return t inside {1, 2, 3, 4, 5, 8};
        if (k == 2) return t inside {1, 4, 5, 8};
        return t == 8;
    endfunction
    function automatic bit m_wr(int t);
        return t inside {1, 2, 3, 6, 7, 8};
    endfunction
    function automatic bit m_imm(int t);
        return t inside {2, 3, 4, 5, 6, 7};
    endfunction
    function automatic bit eb(int r);
        return mb[r] && !(wb_valid && wb_rd == r);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (mb[r]) mb[r] = 1'b0;
        mcnt = 0; mstall = 0; mdrain = 1'b0;
        q.delete();
    endtask

    task automatic ins(bit v, int t, int s1, int s2, int s3, int rd);
        dec_valid = v; dec_type = 4'(t);
        dec_rs1 = 5'(s1); dec_rs2 = 5'(s2); dec_rs3 = 5'(s3); dec_rd = 5'(rd);
    endtask

    task automatic wb(bit v, int r);
        wb_valid = v; wb_rd = 5'(r);
    endtask

    // one clock: predict and compare at negedge, advance the model at posedge
    task automatic cyc();
        bit rdy, tr, hz, wbh;
        int t;
        logic [31:0] m;
        t   = int'(dec_type);
        wbh = wb_valid && mb[wb_rd];
        tr  = m_wr(t) && dec_rd != 0;
        hz  = (m_src(t, 1) && eb(dec_rs1)) || (m_src(t, 2) && eb(dec_rs2))
           || (m_src(t, 3) && eb(dec_rs3)) || (tr && eb(dec_rd))
           || (tr && mcnt == MAXO && !wbh);
        rdy = !mdrain && !flush && !hz;
        for (int r = 0; r < 32; r++) m[r] = mb[r];
        @(negedge clock);
        check("dec_ready", dec_ready, rdy);
        check("stall", stall, dec_valid && !rdy);
        check("busy_mask", busy_mask, m);
        check("outstanding", outstanding, mcnt);
        check("stall_cycles", stall_cycles, mstall);
        @(posedge clock);
        if (wbh) begin mb[wb_rd] = 1'b0; mcnt--; end
        if (dec_valid && rdy) begin
            if (tr) begin mb[dec_rd] = 1'b1; mcnt++; end
            if (t != 0) q.push_back('{w: m_wr(t), i: m_imm(t)});
        end
        if (dec_valid && !rdy && mstall < 65535) mstall++;
        if (!mdrain) mdrain = flush;
        else if (mcnt == 0) mdrain = 1'b0;
        #1;
    endtask

    task automatic idle();
        ins(0, 0, 0, 0, 0, 0); wb(0, 0); flush = 1'b0;
    endtask

    // issue monitor: every expected issue must appear exactly one cycle after its accept
    always @(negedge clock) begin
        if (reset_n && (issue_valid || q.size() != 0)) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got issue_valid=1, expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (issue_valid !== 1'b1 || issue_is_write !== e.w || issue_is_immediate !== e.i) begin
                    n_fail++;
                    $display("FAIL issue: got v=%b w=%b i=%b, expected v=1 w=%b i=%b at %0t",
                             issue_valid, issue_is_write, issue_is_immediate, e.w, e.i, $time);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock) #1;
        check("reset_issue_valid", issue_valid, 0);
        check("reset_busy", busy_mask, 0);
        check("reset_outstanding", outstanding, 0);
        // producer x3 <- x1, x2
        ins(1, INST_R, 1, 2, 0, 3); cyc();
        check("tp1_issue_valid", issue_valid, 1);
        check("tp1_issue_write", issue_is_write, 1);
        check("tp1_busy", busy_mask, 32'h8);
        check("tp1_outstanding", outstanding, 1);
        // dependent x4 <- x3 waits for the writeback of x3
        ins(1, INST_I, 3, 0, 0, 4); repeat (3) cyc();
        wb(1, 3); cyc(); idle();
        check("tp2_busy", busy_mask, 32'h10);
        check("tp2_stall_cycles", stall_cycles, 3);
        wb(1, 4); cyc(); idle();
        // fill to the outstanding limit
        for (int r = 5; r <= 8; r++) begin ins(1, INST_R, 0, 0, 0, r); cyc(); end
        ins(1, INST_U, 0, 0, 0, 9); #1 check("tp3_full_stall", stall, 1); cyc();
        ins(1, INST_B, 1, 2, 0, 0); #1 check("tp3_b_ready", dec_ready, 1); cyc(); idle();
        for (int r = 5; r <= 7; r++) begin wb(1, r); cyc(); end
        idle();
        // same-rd accept and writeback: set wins, count unchanged
        ins(1, INST_R, 1, 2, 0, 10); cyc();
        wb(1, 10); cyc(); idle();
        check("tp4_busy10", busy_mask[10], 1);
        check("tp4_outstanding", outstanding, 2);
        // flush with two writes in flight, decode held
        ins(1, INST_R, 1, 2, 0, 11); flush = 1'b1; cyc(); flush = 1'b0;
        cyc(); wb(1, 8); cyc(); wb(1, 10); cyc(); wb(0, 0);
        #1 check("tp5_first_run_ready", dec_ready, 1); cyc(); idle();
        wb(1, 11); cyc(); idle();
        // flush with nothing in flight drains exactly one cycle
        ins(1, INST_I, 1, 0, 0, 12); flush = 1'b1; cyc(); flush = 1'b0;
        #1 check("tp5_drain_one", dec_ready, 0); cyc();
        #1 check("tp5_drain_done", dec_ready, 1); cyc(); idle();
        wb(1, 12); cyc(); idle();
        // async reset in the middle of a drain
        ins(1, INST_R, 0, 0, 0, 1); cyc();
        ins(1, INST_R, 0, 0, 0, 2); cyc(); idle();
        flush = 1'b1; cyc(); flush = 1'b0;
        check("tp6_busy_before", busy_mask, 32'h6);
        #1 reset_n = 1'b0;
        #1;
        check("tp6_rst_issue_valid", issue_valid, 0);
        check("tp6_rst_issue_write", issue_is_write, 0);
        check("tp6_rst_issue_imm", issue_is_immediate, 0);
        check("tp6_rst_busy", busy_mask, 0);
        check("tp6_rst_outstanding", outstanding, 0);
        check("tp6_rst_stall_cycles", stall_cycles, 0);
        model_reset();
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock) #1;
        ins(1, INST_R, 1, 2, 0, 3); #1 check("tp6_after_rst_ready", dec_ready, 1); cyc(); idle();
        check("tp6_after_rst_issue", issue_valid, 1);
        // randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            int busy[$];
            foreach (mb[r]) if (mb[r]) busy.push_back(r);
            ins($urandom_range(0, 1), $urandom_range(0, 8), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            wb($urandom_range(0, 2) != 0,
               (busy.size() != 0 && $urandom_range(0, 3) != 0) ?
               busy[$urandom_range(0, busy.size() - 1)] : $urandom_range(0, 7));
            flush = ($urandom_range(0, 29) == 0);
            cyc();
        end
        idle();
        for (int r = 0; r < 32; r++) if (mb[r]) begin wb(1, r); cyc(); end
        idle(); cyc(); cyc();
        check("final_outstanding", outstanding, 0);
        check("final_queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
